regfile_wr_ctrl: RTL and testbench

//  Write-port controller for the 32x32 register file.
//  - After reset, or on command, sequentially clears every register to zero.
//  - Arbitrates the single regfile write port between two requesters:
//    m0 = CPU writeback (priority), m1 = debug/touch-panel input.
//  - Starvation guard for m1.
//  - Sits between the requesters and regfile.{wen,waddr,wdata}. Read ports are untouched.

---
 rtl/regfile_wr_ctrl_pkg.sv | 11 +
 rtl/regfile_wr_arb.sv | 34 +++
 rtl/regfile_wr_ctrl.sv | 82 ++++++++
 tb/tb_regfile_wr_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/regfile_wr_ctrl_pkg.sv
// regfile_wr_ctrl_pkg: shared state encoding, default sizes and a counter-width helper
package regfile_wr_ctrl_pkg;
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int STARVE_DEF = 4;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: m0-priority write-port arbiter with a starvation guard for m1
module regfile_wr_arb
  import regfile_wr_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic clr_start,
  input  logic m0_valid,
  input  logic m1_valid,
  output logic m0_ready,
  output logic m1_ready,
  output logic m0_xfer,
  output logic m1_xfer
);
  localparam int SW = cnt_w(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic force1;
  // m1 is forced through once m0 has won STARVE_MAX times in a row against it
  always_comb begin
    force1 = m1_valid && (starve_cnt == SW'(STARVE_MAX));
    m0_ready = run && !clr_start && !force1;
    m1_ready = run && !clr_start && (force1 || !m0_valid);
    m0_xfer = m0_valid && m0_ready;
    m1_xfer = m1_valid && m1_ready;
  end
  // count m0 wins while m1 waits; any idle m1 cycle or m1 win resets the count
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) starve_cnt <= '0;
    else if (!m1_valid || m1_xfer) starve_cnt <= '0;
    else if (m0_xfer && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: register-file write port controller with clear sequence and two-master arbitration
module regfile_wr_ctrl
  import regfile_wr_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int STARVE_MAX = STARVE_DEF,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr_start,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_data,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_data,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          init_busy,
  output logic          grant_id
);
  localparam int CW = cnt_w(NREG);
  localparam state_t RST_ST = CLR_ON_RESET ? ST_CLEAR : ST_RUN;
  state_t state, state_nxt;
  logic [CW-1:0] clr_cnt, clr_cnt_nxt;
  logic run, m0_xfer, m1_xfer, clr_last;
  assign run = (state == ST_RUN);
  assign init_busy = !run;
  assign clr_last = (clr_cnt == CW'(NREG - 1));
  regfile_wr_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .run      (run),
    .clr_start(clr_start),
    .m0_valid (m0_valid),
    .m1_valid (m1_valid),
    .m0_ready (m0_ready),
    .m1_ready (m1_ready),
    .m0_xfer  (m0_xfer),
    .m1_xfer  (m1_xfer)
  );
  // clear walks 0..NREG-1 then runs; clr_start restarts it from address 0
  always_comb begin
    state_nxt = state;
    clr_cnt_nxt = clr_cnt;
    if (!run) begin
      clr_cnt_nxt = (clr_start || clr_last) ? '0 : clr_cnt + 1'b1;
      state_nxt = (!clr_start && clr_last) ? ST_RUN : ST_CLEAR;
    end else if (clr_start) begin
      state_nxt = ST_CLEAR;
      clr_cnt_nxt = '0;
    end
  end
  // state, clear counter and the registered write port
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= RST_ST;
      clr_cnt <= '0;
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= 1'b0;
    end else begin
      state <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rf_wen <= !run || m0_xfer || m1_xfer;
      if (!run) begin
        rf_waddr <= AW'(clr_cnt);
        rf_wdata <= '0;
      end else if (m0_xfer || m1_xfer) begin
        rf_waddr <= m0_xfer ? m0_addr : m1_addr;
        rf_wdata <= m0_xfer ? m0_data : m1_data;
        grant_id <= m1_xfer;
      end
    end
endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl: directed vector table plus clear/reset sequences for regfile_wr_ctrl
module tb_regfile_wr_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clr_start = 1'b0;
  logic m0_valid = 1'b0, m1_valid = 1'b0;
  logic [4:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_data = '0, m1_data = '0;
  logic m0_ready, m1_ready, rf_wen, init_busy, grant_id;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  int vectors = 0;
  int miscompares = 0;

  regfile_wr_ctrl dut (
    .clk(clk), .resetn(resetn), .clr_start(clr_start),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_data(m0_data),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_data(m1_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .init_busy(init_busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m0v; logic [4:0] m0a; logic [31:0] m0d;
    logic m1v; logic [4:0] m1a; logic [31:0] m1d;
    logic r0; logic r1; logic wen; logic [4:0] wa; logic [31:0] wd; logic gid;
  } vec_t;
  vec_t q[$];

  function automatic vec_t mk(logic m0v, logic [4:0] m0a, logic [31:0] m0d,
                              logic m1v, logic [4:0] m1a, logic [31:0] m1d,
                              logic r0, logic r1, logic wen, logic [4:0] wa,
                              logic [31:0] wd, logic gid);
    vec_t v;
    v.m0v = m0v; v.m0a = m0a; v.m0d = m0d; v.m1v = m1v; v.m1a = m1a; v.m1d = m1d;
    v.r0 = r0; v.r1 = r1; v.wen = wen; v.wa = wa; v.wd = wd; v.gid = gid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("clr_busy", init_busy, 1);
      chk("clr_m0_ready", m0_ready, 0);
      chk("clr_m1_ready", m1_ready, 0);
      @(posedge clk); #1;
      chk("clr_wen", rf_wen, 1);
      chk("clr_waddr", rf_waddr, i);
      chk("clr_wdata", rf_wdata, 0);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_wen"}, rf_wen, 0);
    chk({nm, "_waddr"}, rf_waddr, 0);
    chk({nm, "_wdata"}, rf_wdata, 0);
    chk({nm, "_gid"}, grant_id, 0);
    chk({nm, "_busy"}, init_busy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    q.push_back(mk(1, 5, 32'h12345678, 0, 0, 0, 1, 0, 1, 5, 32'h12345678, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 32'h12345678, 0));
    q.push_back(mk(0, 0, 0, 1, 7, 32'hBEEF, 1, 1, 1, 7, 32'hBEEF, 1));
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) q.push_back(mk(1, 1, 32'h10, 1, 2, 32'h20, 1, 0, 1, 1, 32'h10, 0));
      q.push_back(mk(1, 1, 32'h10, 1, 2, 32'h20, 0, 1, 1, 2, 32'h20, 1));
    end
    q.pop_back();
    for (int j = 0; j < 3; j++) q.pop_back();
    for (int j = 0; j < 3; j++) q.push_back(mk(1, 1, 32'h10, 1, 2, 32'h20, 1, 0, 1, 1, 32'h10, 0));
    q.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 0));
    for (int j = 0; j < 4; j++) q.push_back(mk(1, 1, 32'h10, 1, 2, 32'h20, 1, 0, 1, 1, 32'h10, 0));
    q.push_back(mk(1, 1, 32'h10, 1, 2, 32'h20, 0, 1, 1, 2, 32'h20, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 32'h20, 1));
    for (int j = 1; j <= 3; j++) q.push_back(mk(0, 0, 0, 1, 9, j, 1, 1, 1, 9, j, 1));

    #12;
    chk_zero("rst");
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    @(negedge clk) resetn = 1'b1;
    clear_check(32);
    chk("run_busy", init_busy, 0);
    @(posedge clk); #1;
    chk("run_idle_wen", rf_wen, 0);

    foreach (q[i]) begin
      m0_valid = q[i].m0v; m0_addr = q[i].m0a; m0_data = q[i].m0d;
      m1_valid = q[i].m1v; m1_addr = q[i].m1a; m1_data = q[i].m1d;
      #1;
      chk($sformatf("v%0d_m0_ready", i), m0_ready, q[i].r0);
      chk($sformatf("v%0d_m1_ready", i), m1_ready, q[i].r1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wen", i), rf_wen, q[i].wen);
      chk($sformatf("v%0d_waddr", i), rf_waddr, q[i].wa);
      chk($sformatf("v%0d_wdata", i), rf_wdata, q[i].wd);
      chk($sformatf("v%0d_gid", i), grant_id, q[i].gid);
    end

    m1_valid = 1'b0;
    m0_valid = 1'b1; m0_addr = 6; m0_data = 32'h66;
    #1;
    chk("pre_clr_m0_ready", m0_ready, 1);
    @(posedge clk); #1;
    m0_valid = 1'b0;
    m1_valid = 1'b1; m1_addr = 3; m1_data = 32'hA5;
    clr_start = 1'b1;
    chk("pre_clr_wen", rf_wen, 1);
    chk("pre_clr_waddr", rf_waddr, 6);
    chk("pre_clr_wdata", rf_wdata, 32'h66);
    #1;
    chk("clr_start_m0_ready", m0_ready, 0);
    chk("clr_start_m1_ready", m1_ready, 0);
    @(posedge clk); #1;
    clr_start = 1'b0;
    chk("clr_start_wen", rf_wen, 0);
    clear_check(32);
    chk("post_clr_busy", init_busy, 0);
    chk("post_clr_m1_ready", m1_ready, 1);
    @(posedge clk); #1;
    m1_valid = 1'b0;
    chk("post_clr_wen", rf_wen, 1);
    chk("post_clr_waddr", rf_waddr, 3);
    chk("post_clr_wdata", rf_wdata, 32'hA5);
    chk("post_clr_gid", grant_id, 1);

    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    clear_check(10);
    resetn = 1'b0;
    #1;
    chk_zero("midclr_rst");
    @(negedge clk) resetn = 1'b1;
    clear_check(32);
    chk("final_busy", init_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
